instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv_pkg.sv | 15 +
 rtl/instr_fetch_if.sv | 30 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: machine width, instruction size and
// the fetch-buffer entry layout.
package rv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit boundary: instruction-memory request/response channel, the
// redirect input from execute and the instruction stream to decode.
interface instr_fetch_if;
    import rv_pkg::*;

    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemGnt;
    logic            imemRvalid;
    logic [XLEN-1:0] imemRdata;

    logic            redirect;
    logic [XLEN-1:0] redirectPC;

    logic [XLEN-1:0] Instruction;
    logic [XLEN-1:0] instrPC;
    logic            instrValid;
    logic            instrReady;

    modport master (
        output imemReq, imemAddr, Instruction, instrPC, instrValid,
        input  imemGnt, imemRvalid, imemRdata, redirect, redirectPC, instrReady
    );

    modport slave (
        input  imemReq, imemAddr, Instruction, instrPC, instrValid,
        output imemGnt, imemRvalid, imemRdata, redirect, redirectPC, instrReady
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push and pop in the same cycle are legal even
// when full. Used for both the instruction buffer and the in-order PC queue.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetN || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count alone says which slots hold data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches, tags responses with
// their PC, buffers them for decode and discards in-flight words on redirect.
module instr_fetch
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input logic           clk,
    input logic           resetN,
    instr_fetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  redirect_target;
    logic [XLEN-1:0]  pcq_head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W-1:0] out_next;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W:0]   occupancy;
    logic             fifo_full, fifo_empty;
    logic             pcq_full, pcq_empty;
    logic             grant, resp, live, pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    assign redirect_target = bus.redirectPC & ~XLEN'(INSTR_BYTES - 1);
    assign pop             = bus.instrValid && bus.instrReady;

    // A pop at this edge frees its slot at the same edge, so it counts as space;
    // without that credit a 2-entry buffer could not sustain one fetch per cycle.
    assign occupancy    = {1'b0, fifo_count} + {1'b0, out_count} - {{CNT_W{1'b0}}, pop};
    assign bus.imemReq  = resetN && (occupancy < (CNT_W + 1)'(DEPTH));
    assign bus.imemAddr = fetch_pc;

    assign grant    = bus.imemReq && bus.imemGnt;
    assign resp     = bus.imemRvalid && !pcq_empty;
    assign live     = resp && (drop_count == '0) && !bus.redirect;
    assign out_next = out_count + CNT_W'(grant) - CNT_W'(resp);

    assign push_entry      = '{instr: bus.imemRdata, pc: pcq_head};
    assign bus.instrValid  = resetN && !fifo_empty;
    assign bus.Instruction = bus.instrValid ? head_entry.instr : '0;
    assign bus.instrPC     = bus.instrValid ? head_entry.pc    : '0;

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (live),
        .pop    (pop),
        .flush  (bus.redirect),
        .wdata  (push_entry),
        .rdata  (head_entry),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    // Its occupancy is the outstanding-request count, dropped requests included.
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk    (clk),
        .resetN (resetN),
        .push   (grant),
        .pop    (resp),
        .flush  (1'b0),
        .wdata  (fetch_pc),
        .rdata  (pcq_head),
        .full   (pcq_full),
        .empty  (pcq_empty),
        .count  (out_count)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            fetch_pc   <= RESET_PC;
            drop_count <= '0;
        end else begin
            if (bus.redirect)  fetch_pc <= redirect_target;
            else if (grant)    fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);

            // Everything still in flight after this edge belongs to the old path.
            if (bus.redirect)                       drop_count <= out_next;
            else if (resp && (drop_count != '0))    drop_count <= drop_count - 1'b1;
        end
    end

    no_orphan_response: assert property (@(posedge clk) disable iff (!resetN)
        !(bus.imemRvalid && pcq_empty));
    no_pcq_overflow: assert property (@(posedge clk) disable iff (!resetN)
        !(grant && pcq_full));
    no_fifo_overflow: assert property (@(posedge clk) disable iff (!resetN)
        !(live && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with random latency plus an
// epoch-based model of which fetched words must reach decode, and in what order.
module tb_instr_fetch;
    import rv_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] addr; int due; int epoch; } mem_req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_entry_t;

    logic clk = 1'b0;
    logic resetN;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    mem_req_t    memq[$];
    exp_entry_t  expq[$];
    logic [31:0] log_pcs[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] exp_pc = RESET_PC;

    int          gnt_pct, rdy_pct, lat_min, lat_max, redir_permille;
    logic        rst_low, force_redir, collide_redir;
    logic [31:0] force_target;
    logic        pend_req = 1'b0;
    logic [31:0] pend_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] v;
        v = 'x;
        if (idx < log_pcs.size()) v = log_pcs[idx];
        check(tag, v, exp);
    endtask

    // One clock cycle: drive at posedge+1, observe and update the model at negedge.
    task automatic step();
        bit       resp_now, pop_now, grant_now, redir_now, live_now, req_exp;
        mem_req_t head;
        @(posedge clk);
        #1;
        resetN         = !rst_low;
        bus.imemGnt    = ($urandom_range(99) < gnt_pct);
        resp_now       = resetN && (memq.size() > 0) && (memq[0].due <= cyc);
        bus.imemRvalid = resp_now;
        bus.imemRdata  = resp_now ? mem_word(memq[0].addr) : $urandom();
        bus.instrReady = ($urandom_range(99) < rdy_pct);
        bus.redirect   = force_redir || (resetN && ($urandom_range(999) < redir_permille));
        bus.redirectPC = force_redir ? force_target : $urandom();
        force_redir    = 1'b0;
        #1;
        if (collide_redir && bus.imemReq && bus.imemGnt && bus.imemRvalid) begin
            bus.redirect   = 1'b1;
            bus.redirectPC = force_target;
            collide_redir  = 1'b0;
        end
        @(negedge clk);
        if (!resetN) begin
            check("rst_req",   bus.imemReq,     32'd0);
            check("rst_valid", bus.instrValid,  32'd0);
            check("rst_instr", bus.Instruction, 32'd0);
            check("rst_pc",    bus.instrPC,     32'd0);
            memq.delete();
            expq.delete();
            log_pcs.delete();
            exp_pc   = RESET_PC;
            pend_req = 1'b0;
            epoch++;
        end else begin
            pop_now   = bus.instrValid && bus.instrReady;
            grant_now = bus.imemReq && bus.imemGnt;
            redir_now = bus.redirect;

            check("valid", bus.instrValid, 32'(expq.size() > 0));
            if (expq.size() > 0) begin
                check("head_pc",    bus.instrPC,     expq[0].pc);
                check("head_instr", bus.Instruction, expq[0].instr);
            end
            if (pop_now) begin
                check("stream_pc", bus.instrPC, exp_pc);
                exp_pc += 32'd4;
                log_pcs.push_back(bus.instrPC);
            end
            if (pend_req) begin
                check("req_held",  bus.imemReq,  32'd1);
                check("addr_held", bus.imemAddr, pend_addr);
            end
            // Request allowed exactly when buffered + in flight, less this edge's pop, leaves room.
            req_exp = (expq.size() - int'(pop_now) + memq.size()) < DEPTH;
            check("req", bus.imemReq, 32'(req_exp));
            if (bus.imemReq) check("addr_align", 32'(bus.imemAddr[1:0]), 32'd0);

            live_now = 1'b0;
            if (resp_now) begin
                head     = memq.pop_front();
                live_now = (head.epoch == epoch) && !redir_now;
            end
            if (grant_now)
                memq.push_back('{addr: bus.imemAddr,
                                 due: cyc + int'($urandom_range(lat_max, lat_min)),
                                 epoch: epoch});
            if (pop_now && expq.size() > 0) void'(expq.pop_front());
            if (live_now) expq.push_back('{instr: mem_word(head.addr), pc: head.addr});
            if (redir_now) begin
                expq.delete();
                log_pcs.delete();
                epoch++;
                exp_pc = bus.redirectPC & ~32'h3;
            end
            check("fill_bound", 32'(expq.size() <= DEPTH), 32'd1);
            pend_req  = bus.imemReq && !bus.imemGnt && !redir_now;
            pend_addr = bus.imemAddr;
        end
        cyc++;
    endtask

    task automatic wait_outstanding(input string tag, input int n);
        int k;
        k = 0;
        while (memq.size() < n && k < 20) begin
            step();
            k++;
        end
        check(tag, memq.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        bus.imemGnt = 1'b0;
        bus.imemRvalid = 1'b0;
        bus.imemRdata = '0;
        bus.redirect = 1'b0;
        bus.redirectPC = '0;
        bus.instrReady = 1'b0;
        gnt_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1; redir_permille = 0;
        rst_low = 1'b1; force_redir = 1'b0; collide_redir = 1'b0; force_target = '0;

        // Reset, then latency-1 streaming from RESET_PC.
        repeat (3) step();
        rst_low = 1'b0;
        repeat (6) step();
        check_log("start_pc0", 0, 32'h0000_0000);
        check_log("start_pc1", 1, 32'h0000_0004);
        check_log("start_pc2", 2, 32'h0000_0008);
        log_pcs.delete();
        repeat (8) step();
        check("steady_rate", log_pcs.size(), 8);

        // Decode stall: buffer fills to DEPTH, requests stop, stream resumes intact.
        rdy_pct = 0;
        repeat (10) step();
        check("stall_fill",  expq.size(), DEPTH);
        check("stall_req",   bus.imemReq, 32'd0);
        check("stall_valid", bus.instrValid, 32'd1);
        rdy_pct = 100;
        repeat (6) step();

        // Latency 3, two in flight, redirect to 0x100.
        lat_min = 3; lat_max = 3;
        wait_outstanding("redir_two_out", 2);
        force_target = 32'h0000_0100;
        force_redir  = 1'b1;
        repeat (16) step();
        check_log("redir_first",  0, 32'h0000_0100);
        check_log("redir_second", 1, 32'h0000_0104);

        // Redirect in the same cycle as a grant and a response.
        lat_min = 1; lat_max = 1;
        repeat (4) step();
        force_target  = 32'h0000_0200;
        collide_redir = 1'b1;
        for (int k = 0; k < 20 && collide_redir; k++) step();
        check("collide_hit", 32'(collide_redir), 32'd0);
        repeat (8) step();
        check_log("collide_first",  0, 32'h0000_0200);
        check_log("collide_second", 1, 32'h0000_0204);

        // Wrap through the top of the address space; low target bits ignored.
        force_target = 32'hFFFF_FFFB;
        force_redir  = 1'b1;
        repeat (8) step();
        check_log("wrap_pc0", 0, 32'hFFFF_FFF8);
        check_log("wrap_pc1", 1, 32'hFFFF_FFFC);
        check_log("wrap_pc2", 2, 32'h0000_0000);

        // One-cycle reset with two requests in flight.
        lat_min = 3; lat_max = 3;
        wait_outstanding("midrst_two_out", 2);
        rst_low = 1'b1;
        step();
        rst_low = 1'b0;
        repeat (12) step();
        check_log("midrst_first", 0, RESET_PC);

        // Random traffic: grant gaps, latency 1..4, decode stalls, redirects, rare resets.
        gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 4; redir_permille = 30;
        for (int k = 0; k < 3000; k++) begin
            rst_low = ($urandom_range(999) < 3);
            step();
        end
        rst_low = 1'b0; redir_permille = 0; rdy_pct = 100; gnt_pct = 100;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
